stepper_phase_decoder: RTL

STEPPER_PHASE_DECODER -- requirements
Module: stepper_phase_decoder

---
 rtl/stepper_pkg.sv | 39 +++
 rtl/stepper_phase_decoder_filter.sv | 50 +++++
 rtl/stepper_phase_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared stepper definitions: coil patterns, index width, FSM states.
// Used by the stepper driver and the phase decoder.
package stepper_pkg;

  localparam int IDX_W = 3;

  localparam logic [3:0] PAT_0 = 4'b1000;
  localparam logic [3:0] PAT_1 = 4'b1100;
  localparam logic [3:0] PAT_2 = 4'b0100;
  localparam logic [3:0] PAT_3 = 4'b0110;
  localparam logic [3:0] PAT_4 = 4'b0010;
  localparam logic [3:0] PAT_5 = 4'b0011;
  localparam logic [3:0] PAT_6 = 4'b0001;
  localparam logic [3:0] PAT_7 = 4'b1001;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  // Returns {valid, index}; illegal patterns give valid=0, index=0.
  function automatic logic [IDX_W:0] pat_decode(input logic [3:0] p);
    logic [IDX_W:0] r;
    r = '0;
    case (p)
      PAT_0:   r = {1'b1, 3'd0};
      PAT_1:   r = {1'b1, 3'd1};
      PAT_2:   r = {1'b1, 3'd2};
      PAT_3:   r = {1'b1, 3'd3};
      PAT_4:   r = {1'b1, 3'd4};
      PAT_5:   r = {1'b1, 3'd5};
      PAT_6:   r = {1'b1, 3'd6};
      PAT_7:   r = {1'b1, 3'd7};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_filter.sv
// Two-flop synchronizer plus stability filter for the coil pattern.
// accept pulses once per stable interval, with pattern valid alongside.
module phase_sync_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_phase,
  output logic [3:0] o_pattern,
  output logic       o_accept
);

  localparam logic [7:0] ST8 = 8'(STABLE_CYCLES);

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_last;
  logic [7:0] r_cnt;
  logic       r_acc;
  logic       w_diff;

  assign w_diff    = (r_s2 != r_last);
  assign o_pattern = r_last;
  assign o_accept  = r_acc;

  // Synchronize, then count how long the synchronized value has held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_last <= '0;
      r_cnt  <= '0;
      r_acc  <= 1'b0;
    end else begin
      r_s1   <= i_phase;
      r_s2   <= r_s1;
      r_last <= r_s2;
      if (w_diff) begin
        r_cnt <= 8'd1;
        r_acc <= (ST8 == 8'd1);
      end else if (r_cnt != ST8) begin
        r_cnt <= r_cnt + 8'd1;
        r_acc <= (r_cnt == ST8 - 8'd1);
      end else begin
        r_acc <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes a stepper coil drive pattern into step/dir pulses
// and a signed half-step position count.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              phase,
  input  logic                    clr_pos,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] position,
  output logic                    locked,
  output logic                    err
);

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [3:0]       w_pat;
  logic             w_acc;
  logic [IDX_W:0]   w_dec_res;
  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_delta;
  logic             w_fwd;
  logic             w_rev;

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_step;
  logic             r_err;
  logic             r_dir;
  logic [POS_W-1:0] r_pos;

  phase_sync_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .i_phase  (phase),
    .o_pattern(w_pat),
    .o_accept (w_acc)
  );

  assign w_dec_res = pat_decode(w_pat);
  assign w_valid   = w_dec_res[IDX_W];
  assign w_idx     = w_dec_res[IDX_W-1:0];
  assign w_delta   = w_idx - r_idx;

  assign w_fwd = w_acc && (r_state == ST_LOCKED) && w_valid
                 && (w_delta == 3'd1);
  assign w_rev = w_acc && (r_state == ST_LOCKED) && w_valid
                 && (w_delta == 3'd7);

  assign step     = r_step;
  assign err      = r_err;
  assign dir      = r_dir;
  assign locked   = (r_state == ST_LOCKED);
  assign position = r_pos;

  // Lock FSM: tracks reference index, emits step and err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
      r_idx   <= '0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      if (w_acc) begin
        case (r_state)
          ST_UNLOCKED: begin
            if (w_valid) begin
              r_idx   <= w_idx;
              r_state <= ST_LOCKED;
            end else begin
              r_err <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!w_valid) begin
              r_err   <= 1'b1;
              r_state <= ST_UNLOCKED;
            end else if (w_fwd || w_rev) begin
              r_step <= 1'b1;
              r_dir  <= w_fwd;
              r_idx  <= w_idx;
            end else if (w_delta != 3'd0) begin
              r_err <= 1'b1;
              r_idx <= w_idx;
            end
          end
          default: r_state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  // Position counter; clear takes priority over a coincident step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos <= '0;
    end else if (clr_pos) begin
      r_pos <= '0;
    end else if (w_fwd) begin
      r_pos <= r_pos + POS_ONE;
    end else if (w_rev) begin
      r_pos <= r_pos - POS_ONE;
    end
  end

endmodule
